// File: rtl/nasti_data_mover_if.sv
// NASTI (AXI4) read-address and read-data channels of the data mover.
//
// Handshake: a transfer happens on a rising aclk edge where valid and ready
// are both 1. The source holds valid and its payload stable until that edge.
// The sink may raise or lower ready at any time. The master drives the AR
// payload and arvalid, and drives rready. The slave drives arready, the R
// payload and rvalid.
interface nasti_data_mover_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/nasti_data_mover.sv
// Burst-read DMA engine: reads length bytes from DDR over a NASTI read-master
// port and writes each beat into BRAM. done_o is 1 while idle.
// Optional feature macro: NASTI_DM_ERR_EN enables response/rlast checking.
// When it is not defined, err_o stays 0 and rresp/rlast are ignored.
module nasti_data_mover #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // controller side
    input  logic [ADDR_WIDTH-1:0]   ddr_addr_i,
    input  logic [ADDR_WIDTH-1:0]   bram_addr_i,
    input  logic [ADDR_WIDTH-1:0]   length_i,
    input  logic                    en_i,
    output logic                    done_o,
    output logic                    err_o,
    // DDR read master
    nasti_data_mover_if.master      m,
    // BRAM write port
    output logic                    bram_en_o,
    output logic [DATA_WIDTH/8-1:0] bram_we_o,
    output logic [ADDR_WIDTH-1:0]   bram_waddr_o,
    output logic [DATA_WIDTH-1:0]   bram_wrdata_o,
    // debug: current FSM state (0 IDLE, 1 AR, 2 R, 3 FLUSH)
    output logic [1:0]              state_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SH    = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << SH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_AR    = 2'd1,
        S_R     = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   ddr_ptr_q;    // next DDR address to request
    logic [ADDR_WIDTH-1:0]   bram_ptr_q;   // next BRAM address to write
    logic [ADDR_WIDTH-1:0]   beats_q;      // beats not yet received
    logic [8:0]              burst_cnt_q;  // beats left in the current burst
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [7:0]              arlen_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    done_q;
    logic                    err_q;
    logic                    bram_en_q;
    logic [BYTES-1:0]        bram_we_q;
    logic [ADDR_WIDTH-1:0]   bram_waddr_q;
    logic [DATA_WIDTH-1:0]   bram_wrdata_q;

    // Burst size: the smallest of beats remaining, MAX_BURST and the beats
    // left before the DDR pointer crosses a 4 KB boundary.
    function automatic logic [8:0] calc_burst(input logic [ADDR_WIDTH-1:0] ptr,
                                              input logic [ADDR_WIDTH-1:0] rem);
        logic [12:0] to_4k;
        logic [8:0]  b;
        to_4k = (13'h1000 - {1'b0, ptr[11:0]}) >> SH;
        b     = 9'(MAX_BURST);
        if (rem < ADDR_WIDTH'(b)) b = rem[8:0];
        if (to_4k < 13'(b))       b = to_4k[8:0];
        return b;
    endfunction

    logic [ADDR_WIDTH-1:0] start_ddr_d;
    logic [ADDR_WIDTH-1:0] start_bram_d;
    logic [ADDR_WIDTH-1:0] start_beats_d;
    logic [ADDR_WIDTH-1:0] beats_left_d;
    logic [8:0]            first_burst_d;
    logic [8:0]            next_burst_d;
    logic [ADDR_WIDTH-1:0] ddr_ptr_d;
    logic                  r_beat;
    logic                  last_beat;
    logic                  resp_bad;
    logic                  rlast_bad;

    assign start_ddr_d   = ddr_addr_i & ALIGN_MASK;
    assign start_bram_d  = bram_addr_i & ALIGN_MASK;
    assign start_beats_d = length_i >> SH;
    assign beats_left_d  = beats_q - ADDR_WIDTH'(1);
    assign first_burst_d = calc_burst(start_ddr_d, start_beats_d);
    assign next_burst_d  = calc_burst(ddr_ptr_q, beats_left_d);
    // DDR pointer after the burst now on the AR channel has been accepted
    assign ddr_ptr_d     = ddr_ptr_q + ((ADDR_WIDTH'(arlen_q) + ADDR_WIDTH'(1)) << SH);
    assign r_beat        = (state_q == S_R) && rready_q && m.rvalid;
    // the burst ends on our own beat count, never on rlast
    assign last_beat     = (burst_cnt_q == 9'd1);

`ifdef NASTI_DM_ERR_EN
    assign resp_bad  = (m.rresp != 2'b00);
    assign rlast_bad = (m.rlast != last_beat);
`else
    logic unused_rsp;
    assign resp_bad   = 1'b0;
    assign rlast_bad  = 1'b0;
    assign unused_rsp = ^{m.rresp, m.rlast};
`endif

    // Transfer FSM; every output below comes straight from a register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            ddr_ptr_q     <= '0;
            bram_ptr_q    <= '0;
            beats_q       <= '0;
            burst_cnt_q   <= '0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            done_q        <= 1'b1;
            err_q         <= 1'b0;
            bram_en_q     <= 1'b0;
            bram_we_q     <= '0;
            bram_waddr_q  <= '0;
            bram_wrdata_q <= '0;
        end else begin
            // a BRAM write lasts exactly one cycle
            bram_en_q <= 1'b0;
            bram_we_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (en_i) begin
                        ddr_ptr_q  <= start_ddr_d;
                        bram_ptr_q <= start_bram_d;
                        beats_q    <= start_beats_d;
                        err_q      <= 1'b0;
                        done_q     <= 1'b0;
                        if (start_beats_d == '0) begin
                            // nothing to move: no AXI traffic at all
                            state_q <= S_FLUSH;
                        end else begin
                            state_q   <= S_AR;
                            araddr_q  <= start_ddr_d;
                            arlen_q   <= 8'(first_burst_d - 9'd1);
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    // address and length stay put until the slave takes them
                    if (arvalid_q && m.arready) begin
                        arvalid_q   <= 1'b0;
                        rready_q    <= 1'b1;
                        ddr_ptr_q   <= ddr_ptr_d;
                        burst_cnt_q <= {1'b0, arlen_q} + 9'd1;
                        state_q     <= S_R;
                    end
                end
                S_R: begin
                    if (r_beat) begin
                        bram_en_q     <= ~resp_bad;
                        bram_we_q     <= resp_bad ? '0 : {BYTES{1'b1}};
                        bram_waddr_q  <= bram_ptr_q;
                        bram_wrdata_q <= m.rdata;
                        bram_ptr_q    <= bram_ptr_q + ADDR_WIDTH'(BYTES);
                        beats_q       <= beats_left_d;
                        burst_cnt_q   <= burst_cnt_q - 9'd1;
                        if (resp_bad || rlast_bad) err_q <= 1'b1;
                        if (last_beat) begin
                            rready_q <= 1'b0;
                            if (beats_left_d != '0) begin
                                // next burst goes out the very next cycle
                                state_q   <= S_AR;
                                araddr_q  <= ddr_ptr_q;
                                arlen_q   <= 8'(next_burst_d - 9'd1);
                                arvalid_q <= 1'b1;
                            end else begin
                                state_q <= S_FLUSH;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    // last BRAM write retires this cycle; report idle after it
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m.araddr      = araddr_q;
    assign m.arlen       = arlen_q;
    assign m.arsize      = 3'(SH);
    assign m.arburst     = 2'b01;
    assign m.arvalid     = arvalid_q;
    assign m.rready      = rready_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign bram_en_o     = bram_en_q;
    assign bram_we_o     = bram_we_q;
    assign bram_waddr_o  = bram_waddr_q;
    assign bram_wrdata_o = bram_wrdata_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_nasti_data_mover.sv
// Directed bench for nasti_data_mover: a DDR slave model with optional
// stalls and an injected error response, BRAM/AR monitors, and a linear
// sequence of steps with immediate-assertion checks.
module tb_nasti_data_mover;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] ddr_addr = '0;
    logic [AW-1:0] bram_addr = '0;
    logic [AW-1:0] length = '0;
    logic          en = 1'b0;
    logic          done;
    logic          err;
    logic          bram_en;
    logic [7:0]    bram_we;
    logic [AW-1:0] bram_waddr;
    logic [DW-1:0] bram_wrdata;
    logic [1:0]    state;

    nasti_data_mover_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    nasti_data_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(16)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .ddr_addr_i    (ddr_addr),
        .bram_addr_i   (bram_addr),
        .length_i      (length),
        .en_i          (en),
        .done_o        (done),
        .err_o         (err),
        .m             (axi),
        .bram_en_o     (bram_en),
        .bram_we_o     (bram_we),
        .bram_waddr_o  (bram_waddr),
        .bram_wrdata_o (bram_wrdata),
        .state_o       (state)
    );

    // clock and global time limit
    initial forever #5 aclk = ~aclk;
    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_bad = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    logic [AW-1:0] ar_addr_q[$];
    logic [7:0]    ar_len_q[$];
    int            ar_cyc_q[$];
    int            beat_cyc_q[$];

    bit            stall_en = 1'b0;
    int            err_beat = -1;
    int            beat_idx = 0;
    logic [AW-1:0] s_addr = '0;
    int            s_left = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {~a[31:0], a[31:0]};
    endfunction

    // DDR slave model plus AR / R / BRAM monitors (pre-edge values at posedge)
    initial begin
        logic          ar_hs;
        logic          r_hs;
        logic [AW-1:0] ar_a;
        logic [7:0]    ar_l;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        forever begin
            @(posedge aclk);
            cyc++;
            ar_hs = axi.arvalid && axi.arready;
            r_hs  = axi.rvalid && axi.rready;
            ar_a  = axi.araddr;
            ar_l  = axi.arlen;
            if (aresetn) begin
                if (ar_hs) begin
                    ar_addr_q.push_back(ar_a);
                    ar_len_q.push_back(ar_l);
                    ar_cyc_q.push_back(cyc);
                end
                if (r_hs) beat_cyc_q.push_back(cyc);
                if (bram_en) begin
                    wr_addr_q.push_back(bram_waddr);
                    wr_data_q.push_back(bram_wrdata);
                    if (bram_we != 8'hFF) we_bad++;
                end
            end
            #1;
            if (!aresetn) begin
                s_left      = 0;
                axi.arready = 1'b0;
                axi.rvalid  = 1'b0;
                axi.rlast   = 1'b0;
                axi.rresp   = 2'b00;
            end else begin
                if (ar_hs) begin
                    s_addr = ar_a;
                    s_left = int'(ar_l) + 1;
                end
                if (r_hs) begin
                    s_addr = s_addr + 64'd8;
                    s_left--;
                    beat_idx++;
                end
                axi.arready = (s_left == 0) && (!stall_en || $urandom_range(0, 1) == 1);
                axi.rvalid  = (s_left > 0) && (!stall_en || $urandom_range(0, 2) != 0);
                axi.rdata   = mem_word(s_addr);
                axi.rlast   = (s_left == 1);
                axi.rresp   = (beat_idx == err_beat) ? 2'b10 : 2'b00;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        ar_addr_q.delete();
        ar_len_q.delete();
        ar_cyc_q.delete();
        beat_cyc_q.delete();
        beat_idx = 0;
    endtask

    // en is sampled at edge T; returns at the negedge after T
    task automatic start(input logic [AW-1:0] d, input logic [AW-1:0] b, input logic [AW-1:0] l);
        @(negedge aclk);
        clear_logs();
        ddr_addr  = d;
        bram_addr = b;
        length    = l;
        en        = 1'b1;
        @(negedge aclk);
        en = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        if (!done) check("done_timeout", 64'(done), 64'd1);
        dcyc = cyc;
    endtask

    task automatic check_ar(input int i, input logic [AW-1:0] a, input logic [7:0] l);
        check($sformatf("ar%0d_addr", i), (i < ar_addr_q.size()) ? ar_addr_q[i] : 'x, a);
        check($sformatf("ar%0d_len", i), (i < ar_len_q.size()) ? 64'(ar_len_q[i]) : 'x, 64'(l));
    endtask

    // expected BRAM writes: beat i of the transfer lands at dst+8i with the
    // DDR word at src+8i; beat 'skip' (if >= 0) is not written
    task automatic check_writes(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                input int n, input int skip);
        int j;
        check("wr_count", 64'(wr_addr_q.size()), 64'(n - ((skip >= 0) ? 1 : 0)));
        j = 0;
        for (int i = 0; i < n; i++) begin
            if (i != skip) begin
                check($sformatf("wr%0d_addr", i), (j < wr_addr_q.size()) ? wr_addr_q[j] : 'x,
                      dst + 64'(8 * i));
                check($sformatf("wr%0d_data", i), (j < wr_data_q.size()) ? wr_data_q[j] : 'x,
                      mem_word(src + 64'(8 * i)));
                j++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_arvalid"}, 64'(axi.arvalid), 64'd0);
        check({tag, "_rready"}, 64'(axi.rready), 64'd0);
        check({tag, "_bram_en"}, 64'(bram_en), 64'd0);
        check({tag, "_bram_we"}, 64'(bram_we), 64'd0);
        check({tag, "_araddr"}, axi.araddr, 64'd0);
        check({tag, "_waddr"}, bram_waddr, 64'd0);
        check({tag, "_wrdata"}, bram_wrdata, 64'd0);
        check({tag, "_state"}, 64'(state), 64'd0);
    endtask

    initial begin
        int dcyc;
        int n;

        // ---- reset ----
        repeat (2) @(negedge aclk);
        check_reset_outputs("rst");
        aresetn = 1'b1;
        @(negedge aclk);
        check("rst_idle_state", 64'(state), 64'd0);

        // ---- basic transfer: 8 beats, one burst ----
        start(64'h1000, 64'h40, 64'd64);
        check("basic_done_low", 64'(done), 64'd0);
        check("basic_arvalid", 64'(axi.arvalid), 64'd1);
        check("basic_araddr", axi.araddr, 64'h1000);
        check("basic_arlen", 64'(axi.arlen), 64'd7);
        check("basic_arsize", 64'(axi.arsize), 64'd3);
        check("basic_arburst", 64'(axi.arburst), 64'd1);
        wait_done(dcyc);
        check("basic_ar_count", 64'(ar_addr_q.size()), 64'd1);
        check_ar(0, 64'h1000, 8'd7);
        check_writes(64'h1000, 64'h40, 8, -1);
        // last beat at edge E -> done sampled high from edge E+2 on
        check("basic_done_timing", 64'(dcyc - beat_cyc_q[$]), 64'd1);
        check("basic_err", 64'(err), 64'd0);

        // ---- burst splitting: 40 beats -> 16, 16, 8 ----
        start(64'h1000, 64'h0, 64'd320);
        wait_done(dcyc);
        check("split_ar_count", 64'(ar_addr_q.size()), 64'd3);
        check_ar(0, 64'h1000, 8'd15);
        check_ar(1, 64'h1080, 8'd15);
        check_ar(2, 64'h1100, 8'd7);
        check_writes(64'h1000, 64'h0, 40, -1);
        check("split_next_ar1", 64'(ar_cyc_q[1] - beat_cyc_q[15]), 64'd1);
        check("split_next_ar2", 64'(ar_cyc_q[2] - beat_cyc_q[31]), 64'd1);

        // ---- 4 KB boundary: 2 beats before 0x2000, then 6 ----
        start(64'h1FF0, 64'h400, 64'd64);
        wait_done(dcyc);
        check("4k_ar_count", 64'(ar_addr_q.size()), 64'd2);
        check_ar(0, 64'h1FF0, 8'd1);
        check_ar(1, 64'h2000, 8'd5);
        check_writes(64'h1FF0, 64'h400, 8, -1);

        // ---- zero and sub-beat lengths ----
        start(64'h1000, 64'h0, 64'd0);
        check("zero_done_low", 64'(done), 64'd0);
        check("zero_arvalid", 64'(axi.arvalid), 64'd0);
        @(negedge aclk);
        check("zero_done_high", 64'(done), 64'd1);
        check("zero_ar_count", 64'(ar_addr_q.size()), 64'd0);
        check("zero_wr_count", 64'(wr_addr_q.size()), 64'd0);
        start(64'h1000, 64'h0, 64'd5);
        check("sub_done_low", 64'(done), 64'd0);
        check("sub_arvalid", 64'(axi.arvalid), 64'd0);
        @(negedge aclk);
        check("sub_done_high", 64'(done), 64'd1);
        check("sub_ar_count", 64'(ar_addr_q.size()), 64'd0);
        check("sub_wr_count", 64'(wr_addr_q.size()), 64'd0);

        // ---- en held high: a new transfer starts on return to IDLE ----
        @(negedge aclk);
        length = 64'd0;
        en     = 1'b1;
        @(negedge aclk);
        check("hold_done_t1", 64'(done), 64'd0);
        @(negedge aclk);
        check("hold_done_t2", 64'(done), 64'd1);
        @(negedge aclk);
        check("hold_done_t3", 64'(done), 64'd0);
        en = 1'b0;
        @(negedge aclk);
        check("hold_done_t4", 64'(done), 64'd1);
        @(negedge aclk);
        check("hold_done_t5", 64'(done), 64'd1);

        // ---- backpressure: 25 beats from 0x3008 with random stalls ----
        stall_en = 1'b1;
        start(64'h3008, 64'h100, 64'd200);
        wait_done(dcyc);
        stall_en = 1'b0;
        check("bp_ar_count", 64'(ar_addr_q.size()), 64'd2);
        check_ar(0, 64'h3008, 8'd15);
        check_ar(1, 64'h3088, 8'd8);
        check_writes(64'h3008, 64'h100, 25, -1);

        // ---- reset pulse in the middle of the R phase ----
        start(64'h1000, 64'h200, 64'd64);
        n = 0;
        while (beat_idx < 3 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("mid_reached_r", 64'(state), 64'd2);
        aresetn = 1'b0;
        #1;
        check_reset_outputs("mid");
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("mid_after_idle", 64'(state), 64'd0);
        start(64'h1FF0, 64'h400, 64'd64);
        wait_done(dcyc);
        check("recover_ar_count", 64'(ar_addr_q.size()), 64'd2);
        check_writes(64'h1FF0, 64'h400, 8, -1);

        // ---- error response on the third beat ----
        err_beat = 2;
        start(64'h1000, 64'h40, 64'd64);
        wait_done(dcyc);
        err_beat = -1;
`ifdef NASTI_DM_ERR_EN
        check_writes(64'h1000, 64'h40, 8, 2);
        check("errbeat_err", 64'(err), 64'd1);
        start(64'h1000, 64'h0, 64'd0);
        check("errbeat_err_cleared", 64'(err), 64'd0);
        @(negedge aclk);
`else
        check_writes(64'h1000, 64'h40, 8, -1);
        check("errbeat_err_tied", 64'(err), 64'd0);
`endif

        check("bram_we_all_ones", 64'(we_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nasti_data_mover.md
# nasti_data_mover

Burst-read DMA engine that sits directly downstream of the data-mover controller. It takes the controller's latched DDR address, BRAM address, byte length and enable, fetches the data from DDR over a NASTI (AXI4) read-master port, and writes each beat into on-chip BRAM. Its `done` output is the controller's only status input: low while a transfer is in progress, high when idle.

## Interface
- `ADDR_WIDTH`, 64, width of all address and length buses.
- `DATA_WIDTH`, 64, data beat width; must be a power of two ≥ 8. BYTES = DATA_WIDTH/8.
- `MAX_BURST`, 16, maximum beats per AR burst, 1..256.
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `ddr_addr`  in  ADDR_WIDTH  source byte address.
- `bram_addr`  in  ADDR_WIDTH  destination byte address.
- `length`  in  ADDR_WIDTH  transfer length in bytes.
- `en`  in  1  start request, level-sampled in IDLE.
- `done`  out  1  1 = idle; 0 = transfer in progress.
- `err`  out  1  sticky error flag for the current or last transfer.
- `m_araddr`  out  ADDR_WIDTH  burst start address.
- `m_arlen`  out  8  beats−1.
- `m_arsize`  out  3  constant log2(BYTES).
- `m_arburst`  out  2  constant 2'b01 (INCR).
- `m_arvalid` / `m_arready`  out / in  1  AR handshake.
- `m_rdata`  in  DATA_WIDTH  read data.
- `m_rresp`  in  2  read response.
- `m_rlast`  in  1  last beat of the burst.
- `m_rvalid` / `m_rready`  in / out  1  R handshake.
- `bram_en`  out  1  BRAM write enable.
- `bram_we`  out  BYTES  byte write strobes.
- `bram_waddr`  out  ADDR_WIDTH  BRAM byte address.
- `bram_wrdata`  out  DATA_WIDTH  BRAM write data.

## Operation
- States: IDLE, AR, R, FLUSH.
- **IDLE:** `done`=1. When `en`=1, latch three values and go to AR:
  - DDR pointer = `ddr_addr` with the low log2(BYTES) bits cleared.
  - BRAM pointer = `bram_addr` with the low log2(BYTES) bits cleared.
  - beats = `length` >> log2(BYTES); remainder bytes are ignored.
  - Also clear `err`.
- **Zero-beat request:** go to FLUSH instead of AR; no AXI traffic.
- **AR:**
  - Burst beats = min(beats remaining, MAX_BURST, beats until the next 4 KB boundary of the DDR pointer).
  - Drive `m_araddr` = DDR pointer and `m_arlen` = burst beats−1, with `m_arvalid`=1. Outputs are stable until `m_arready`.
  - On the handshake: advance the DDR pointer by burst·BYTES and go to R.
- **R:** `m_rready`=1. Each beat accepted with `m_rvalid`&`m_rready`:
  - Register the data into the BRAM write port.
  - Increment the BRAM pointer by BYTES; it wraps modulo 2^ADDR_WIDTH.
  - Decrement the remaining-beat count.
- **End of burst:** a burst ends on the internal beat counter, not on `m_rlast`. Then go to AR if beats remain, else FLUSH.
- **FLUSH:** one cycle, then IDLE.
- **Outstanding bursts:** only one burst is outstanding at a time.
- **`en` held high:** if `en` is still 1 when the block returns to IDLE, a new transfer starts. The controller is required to drop `en` while `done`=0.
- **Reset mid-operation:** everything returns to its reset value and the current transfer is abandoned. The DDR slave must share the reset.

## Timing
- **Reset values:** `done`=1, `err`=0, `m_arvalid`=0, `m_rready`=0, `bram_en`=0, `bram_we`=0, state IDLE. Address and data outputs are 0.
- **Start:** `en` sampled 1 at edge T → `done`=0 and `m_arvalid`=1 from T+1.
- **BRAM write latency:** a beat accepted at edge E → `bram_en`=1, `bram_we`=all ones, `bram_waddr`, `bram_wrdata` valid for exactly the cycle after E.
- **Completion:** final beat accepted at E → FLUSH during E..E+1 → `done`=1 at E+2, after the last BRAM write has retired.
- **Zero-beat request:** `done` is low for exactly one cycle.
- **Next burst:** AR for the next burst is asserted the cycle after the previous burst's last beat.

## Configuration
- `NASTI_DM_ERR_EN` defined:
  - A beat with `m_rresp`≠2'b00 is not written (`bram_en`=0 that cycle) and sets `err`.
  - `m_rlast` disagreeing with the internal last-beat decision sets `err`.
  - The transfer still runs to completion.
- Undefined: `err` is tied 0, every beat is written, and `m_rresp` and `m_rlast` are ignored.

## Test plan
- **Basic transfer:** ddr_addr=0x1000, bram_addr=0x40, length=64, slave always ready → one AR (araddr=0x1000, arlen=7); 8 BRAM writes at 0x40..0x78; `done` high 2 cycles after the last beat.
- **Burst splitting:** length=320 (40 beats), MAX_BURST=16 → arlen 15, 15, 7 at 0x1000, 0x1080, 0x1100.
- **4 KB split:** ddr_addr=0x1FF0, length=64 → bursts arlen=1 at 0x1FF0, then arlen=5 at 0x2000.
- **Zero and sub-beat length:** length=0, then length=5 → each gives `done` low for one cycle, `m_arvalid` never asserted, no BRAM write.
- **Backpressure and reset:** random `m_arready`/`m_rvalid` stalls → data order and addresses unchanged. `aresetn` pulsed mid-R → all outputs at reset values immediately, IDLE.
- **Error handling (`NASTI_DM_ERR_EN`):** rresp=2'b10 on beat 3 of 8 → 7 writes, beat 3 skipped; `err`=1 at `done`; `err` cleared on the next start.
